countdown_timer_mux: RTL and testbench



---
 rtl/countdown_timer_mux.sv | 205 ++++++++++++++++++++
 tb/tb_countdown_timer_mux.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_mux.sv
// Multi-digit BCD countdown timer with pause/abort and a multiplexed 7-segment scan driver.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shows).
module countdown_timer_mux #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pause_req,
    input  logic                    abort,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    output logic                    counting,
    output logic                    paused,
    output logic                    done,
    output logic                    aborted,
    output logic [4*NUM_DIGITS-1:0] value_bcd,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel
);

    localparam int unsigned VW = 4 * NUM_DIGITS;
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StPause = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [VW-1:0]         value_q, value_d;
    logic                  counting_q, paused_q, done_q, done_d, aborted_q, aborted_d;
    logic [SW-1:0]         scan_q;
    logic [IW-1:0]         index_q;
    logic [7:0]            seg_q, cur_pat;
    logic [NUM_DIGITS-1:0] sel_q, cur_sel;
    logic [VW-1:0]         clamped, decremented;
    logic [3:0]            nib, ld_nib;
    logic                  borrow;
    logic                  scan_wrap;

    function automatic logic [7:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    seg_pattern = 8'h3F;
            4'd1:    seg_pattern = 8'h06;
            4'd2:    seg_pattern = 8'h5B;
            4'd3:    seg_pattern = 8'h4F;
            4'd4:    seg_pattern = 8'h66;
            4'd5:    seg_pattern = 8'h6D;
            4'd6:    seg_pattern = 8'h7D;
            4'd7:    seg_pattern = 8'h07;
            4'd8:    seg_pattern = 8'h7F;
            4'd9:    seg_pattern = 8'h6F;
            default: seg_pattern = 8'h00;
        endcase
    endfunction

    // Per-digit load clamp and ripple-borrow BCD decrement.
    always_comb begin
        clamped     = '0;
        decremented = '0;
        nib         = '0;
        ld_nib      = '0;
        borrow      = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib    = value_q[4*i +: 4];
            ld_nib = load_bcd[4*i +: 4];
            clamped[4*i +: 4] = (ld_nib > 4'd9) ? 4'd9 : ld_nib;
            if (borrow) begin
                if (nib == 4'd0) begin
                    decremented[4*i +: 4] = 4'd9;
                end else begin
                    decremented[4*i +: 4] = nib - 4'd1;
                    borrow = 1'b0;
                end
            end else begin
                decremented[4*i +: 4] = nib;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        value_d   = value_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    value_d = clamped;
                    tick_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    tick_d    = '0;
                    state_d   = StIdle;
                end else if (pause_req) begin
                    state_d = StPause;
                end else if (tick_q == TW'(TICK_DIV - 1)) begin
                    tick_d = '0;
                    if (value_q == '0) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        value_d = decremented;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StPause: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    tick_d    = '0;
                    state_d   = StIdle;
                end else if (pause_req) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            value_q    <= '0;
            counting_q <= 1'b0;
            paused_q   <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            value_q    <= value_d;
            counting_q <= (state_d != StIdle);
            paused_q   <= (state_d == StPause);
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;
    logic                  upper_zero;
`endif

    // Pattern for the digit currently indexed; latched into seg on slot wrap.
    always_comb begin
        cur_pat = 8'h00;
        cur_sel = '0;
`ifdef LEADING_ZERO_BLANK_EN
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero && (value_q[4*i +: 4] == 4'd0);
            blank[i]   = upper_zero;
        end
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_q == IW'(i)) begin
                cur_sel[i] = 1'b1;
                cur_pat    = seg_pattern(value_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
                if (blank[i]) cur_pat = 8'h00;
`endif
            end
        end
    end

    assign scan_wrap = (scan_q == SW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q  <= '0;
            index_q <= '0;
            seg_q   <= 8'h00;
            sel_q   <= NUM_DIGITS'(1);
        end else if (scan_wrap) begin
            scan_q  <= '0;
            index_q <= (index_q == IW'(NUM_DIGITS - 1)) ? '0 : index_q + 1'b1;
            seg_q   <= cur_pat;
            sel_q   <= cur_sel;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    assign counting  = counting_q;
    assign paused    = paused_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign value_bcd = value_q;
    assign seg       = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_countdown_timer_mux.sv
// Directed self-checking bench for countdown_timer_mux (NUM_DIGITS=2, TICK_DIV=10, SCAN_DIV=4).
module tb_countdown_timer_mux;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pause_req;
    logic       abort;
    logic [7:0] load_bcd;
    logic       counting;
    logic       paused;
    logic       done;
    logic       aborted;
    logic [7:0] value_bcd;
    logic [7:0] seg;
    logic [1:0] digit_sel;

    int total;
    int bad;

    countdown_timer_mux #(
        .NUM_DIGITS(2),
        .TICK_DIV  (10),
        .SCAN_DIV  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pause_req(pause_req),
        .abort    (abort),
        .load_bcd (load_bcd),
        .counting (counting),
        .paused   (paused),
        .done     (done),
        .aborted  (aborted),
        .value_bcd(value_bcd),
        .seg      (seg),
        .digit_sel(digit_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus tasks start and end just after a falling edge.
    task automatic do_start(input logic [7:0] v);
        start    = 1'b1;
        load_bcd = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (counting !== 1'b0) begin bad++; $display("FAIL reset_counting got=%b exp=0", counting); end
        total++; if (paused !== 1'b0) begin bad++; $display("FAIL reset_paused got=%b exp=0", paused); end
        total++; if (done !== 1'b0 || aborted !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", done, aborted); end
        total++; if (value_bcd !== 8'h00) begin bad++; $display("FAIL reset_value got=%h exp=00", value_bcd); end
        total++; if (seg !== 8'h00) begin bad++; $display("FAIL reset_seg got=%h exp=00", seg); end
        total++; if (digit_sel !== 2'b01) begin bad++; $display("FAIL reset_sel got=%b exp=01", digit_sel); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_expiry();
        // pause_req and abort are ignored in IDLE
        pause_req = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        pause_req = 1'b0;
        abort     = 1'b0;
        total++; if (counting !== 1'b0 || aborted !== 1'b0 || paused !== 1'b0) begin bad++; $display("FAIL idle_ignore got=%b%b%b exp=000", counting, aborted, paused); end
        do_start(8'h03);
        total++; if (value_bcd !== 8'h03 || counting !== 1'b1) begin bad++; $display("FAIL expiry_load got=%h/%b exp=03/1", value_bcd, counting); end
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k == 9) begin
                total++; if (value_bcd !== 8'h03) begin bad++; $display("FAIL expiry_k9 got=%h exp=03", value_bcd); end
            end
            if (k == 10) begin
                total++; if (value_bcd !== 8'h02) begin bad++; $display("FAIL expiry_k10 got=%h exp=02", value_bcd); end
            end
            if (k == 20) begin
                total++; if (value_bcd !== 8'h01) begin bad++; $display("FAIL expiry_k20 got=%h exp=01", value_bcd); end
            end
            if (k == 30) begin
                total++; if (value_bcd !== 8'h00) begin bad++; $display("FAIL expiry_k30 got=%h exp=00", value_bcd); end
            end
            if (k == 39) begin
                total++; if (done !== 1'b0 || counting !== 1'b1) begin bad++; $display("FAIL expiry_k39 got=done%b/cnt%b exp=done0/cnt1", done, counting); end
            end
            if (k == 40) begin
                total++; if (done !== 1'b1 || counting !== 1'b0 || value_bcd !== 8'h00) begin bad++; $display("FAIL expiry_k40 got=done%b/cnt%b/%h exp=done1/cnt0/00", done, counting, value_bcd); end
            end
            if (k == 41) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL expiry_k41 got=%b exp=0", done); end
            end
        end
    endtask

    task automatic test_borrow_clamp();
        do_start(8'h1F);
        total++; if (value_bcd !== 8'h19) begin bad++; $display("FAIL clamp_load got=%h exp=19", value_bcd); end
        repeat (10) @(negedge clk);
        total++; if (value_bcd !== 8'h18) begin bad++; $display("FAIL clamp_dec got=%h exp=18", value_bcd); end
        pulse_abort();
        total++; if (aborted !== 1'b1 || counting !== 1'b0 || value_bcd !== 8'h18) begin bad++; $display("FAIL abort_run got=ab%b/cnt%b/%h exp=ab1/cnt0/18", aborted, counting, value_bcd); end
        @(negedge clk);
        total++; if (aborted !== 1'b0) begin bad++; $display("FAIL abort_pulse_width got=%b exp=0", aborted); end
        do_start(8'h10);
        repeat (10) @(negedge clk);
        total++; if (value_bcd !== 8'h09) begin bad++; $display("FAIL borrow_10 got=%h exp=09", value_bcd); end
        pulse_abort();
    endtask

    task automatic test_pause();
        do_start(8'h05);
        repeat (4) @(negedge clk);
        pause_req = 1'b1;
        @(negedge clk);
        pause_req = 1'b0;
        total++; if (paused !== 1'b1 || counting !== 1'b1) begin bad++; $display("FAIL pause_enter got=p%b/c%b exp=p1/c1", paused, counting); end
        repeat (24) @(negedge clk);
        total++; if (value_bcd !== 8'h05 || paused !== 1'b1) begin bad++; $display("FAIL pause_hold got=%h/p%b exp=05/p1", value_bcd, paused); end
        pause_req = 1'b1;
        @(negedge clk);
        pause_req = 1'b0;
        total++; if (paused !== 1'b0 || counting !== 1'b1) begin bad++; $display("FAIL pause_resume got=p%b/c%b exp=p0/c1", paused, counting); end
        repeat (5) @(negedge clk);
        total++; if (value_bcd !== 8'h05) begin bad++; $display("FAIL resume_r5 got=%h exp=05", value_bcd); end
        @(negedge clk);
        total++; if (value_bcd !== 8'h04) begin bad++; $display("FAIL resume_r6 got=%h exp=04", value_bcd); end
        // abort from PAUSE
        pause_req = 1'b1;
        @(negedge clk);
        pause_req = 1'b0;
        pulse_abort();
        total++; if (aborted !== 1'b1 || paused !== 1'b0 || counting !== 1'b0) begin bad++; $display("FAIL abort_pause got=ab%b/p%b/c%b exp=ab1/p0/c0", aborted, paused, counting); end
    endtask

    task automatic test_abort_race();
        int done_seen;
        done_seen = 0;
        do_start(8'h01);
        repeat (19) @(negedge clk);
        total++; if (value_bcd !== 8'h00 || counting !== 1'b1) begin bad++; $display("FAIL race_pre got=%h/c%b exp=00/c1", value_bcd, counting); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (aborted !== 1'b1 || done !== 1'b0 || counting !== 1'b0) begin bad++; $display("FAIL race_edge got=ab%b/d%b/c%b exp=ab1/d0/c0", aborted, done, counting); end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL race_no_done got=%0d exp=0", done_seen); end
        do_start(8'h25);
        total++; if (value_bcd !== 8'h25 || counting !== 1'b1) begin bad++; $display("FAIL race_reload got=%h/c%b exp=25/c1", value_bcd, counting); end
        repeat (2) @(negedge clk);
        do_start(8'h99);
        total++; if (value_bcd !== 8'h25) begin bad++; $display("FAIL start_in_run got=%h exp=25", value_bcd); end
        pulse_abort();
    endtask

    task automatic test_scan();
        logic [1:0] prev_sel;
        int         changes;
        do_start(8'h42);
        pulse_abort();
        repeat (10) @(negedge clk);
        prev_sel = digit_sel;
        changes  = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (digit_sel !== prev_sel) changes++;
            prev_sel = digit_sel;
            total++;
            if (!((digit_sel === 2'b01 && seg === 8'h5B) || (digit_sel === 2'b10 && seg === 8'h66))) begin
                bad++; $display("FAIL scan_42 got=sel%b/seg%h exp=sel01/seg5B or sel10/seg66", digit_sel, seg);
            end
        end
        total++; if (changes !== 4) begin bad++; $display("FAIL scan_rate got=%0d exp=4", changes); end
        do_start(8'h07);
        pulse_abort();
        repeat (10) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
`ifdef LEADING_ZERO_BLANK_EN
            if (!((digit_sel === 2'b01 && seg === 8'h07) || (digit_sel === 2'b10 && seg === 8'h00))) begin
                bad++; $display("FAIL scan_07 got=sel%b/seg%h exp=sel01/seg07 or sel10/seg00", digit_sel, seg);
            end
`else
            if (!((digit_sel === 2'b01 && seg === 8'h07) || (digit_sel === 2'b10 && seg === 8'h3F))) begin
                bad++; $display("FAIL scan_07 got=sel%b/seg%h exp=sel01/seg07 or sel10/seg3F", digit_sel, seg);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        pulses = 0;
        do_start(8'h03);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (counting !== 1'b0 || paused !== 1'b0 || value_bcd !== 8'h00) begin bad++; $display("FAIL rst_mid_state got=c%b/p%b/%h exp=c0/p0/00", counting, paused, value_bcd); end
        total++; if (seg !== 8'h00 || digit_sel !== 2'b01) begin bad++; $display("FAIL rst_mid_disp got=seg%h/sel%b exp=seg00/sel01", seg, digit_sel); end
        total++; if (done !== 1'b0 || aborted !== 1'b0) begin bad++; $display("FAIL rst_mid_pulse got=d%b/a%b exp=d0/a0", done, aborted); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done === 1'b1 || aborted === 1'b1 || counting === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rst_mid_after got=%0d exp=0", pulses); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        pause_req = 1'b0;
        abort     = 1'b0;
        load_bcd  = 8'h00;
        test_reset();
        test_expiry();
        test_borrow_clamp();
        test_pause();
        test_abort_race();
        test_scan();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
